// File: rtl/calc_display_driver.sv
// calc_display_driver: sequential double-dabble binary-to-BCD plus an 8-digit multiplexed 7-segment scan.
// Optional feature: define DISP_SIGNED_EN to treat value as two's complement with a '-' sign digit.
module calc_display_driver #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    input  logic [31:0] value,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy
);
    // state | meaning
    // IDLE  | digits stable; start when value differs from last_value or force is set
    // LOAD  | capture operand into shift register, clear BCD scratch
    // SHIFT | 32 add-3/shift steps
    // DONE  | commit digits (or error pattern), update last_value, clear force
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int         RW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0] CODE_DASH = 4'hA;

    state_t        state_q, state_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [31:0]   cap_q, cap_d;
    logic [31:0]   last_q, last_d;
    logic [31:0]   digits_q, digits_d;
    logic [39:0]   bcd_q, bcd_d, bcd_adj;
    logic [4:0]    cnt_q, cnt_d;
    logic          force_q, force_d;
    logic [31:0]   result;
    logic          ovf;
    logic [RW-1:0] ref_q;
    logic [2:0]    idx_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic [7:0]    blank;
    logic          allz;
    logic [3:0]    sel;
`ifdef DISP_SIGNED_EN
    logic          neg_q, neg_d;
    logic [2:0]    top;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        case (c)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0111111;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Final digit codes; the sign dash sits just left of the highest nonzero digit.
    always_comb begin
        result = bcd_q[31:0];
`ifdef DISP_SIGNED_EN
        ovf = |bcd_q[39:28];
        top = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) top = 3'(i);
        end
        if (neg_q) begin
            for (int i = 0; i < 7; i++) begin
                if (top == 3'(i)) result[4*(i+1) +: 4] = CODE_DASH;
            end
        end
`else
        ovf = |bcd_q[39:32];
`endif
        if (ovf) result = {8{CODE_DASH}};
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        cap_d    = cap_q;
        last_d   = last_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        force_d  = force_q;
`ifdef DISP_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (value != last_q || force_q) state_d = LOAD;
            end
            LOAD: begin
                cap_d = value;
`ifdef DISP_SIGNED_EN
                neg_d   = value[31];
                shreg_d = value[31] ? (~value + 32'd1) : value;
`else
                shreg_d = value;
`endif
                bcd_d   = '0;
                cnt_d   = 5'd31;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = DONE;
            end
            DONE: begin
                digits_d = result;
                last_d   = cap_q;
                force_d  = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bcd_q    <= '0;
            cap_q    <= '0;
            last_q   <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            force_q  <= 1'b1;
`ifdef DISP_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bcd_q    <= bcd_d;
            cap_q    <= cap_d;
            last_q   <= last_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            force_q  <= force_d;
`ifdef DISP_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    always_comb begin
        allz = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            allz     = allz && (digits_q[4*i +: 4] == 4'd0);
            blank[i] = BLANK_LZ && allz && (i != 0);
        end
    end

    assign sel = digits_q[{idx_q, 2'b00} +: 4];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ref_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
        end else begin
            if (ref_q == RW'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            an_q  <= en ? ~(8'b1 << idx_q) : 8'hFF;
            seg_q <= (en && !blank[idx_q]) ? seg_decode(sel) : 7'h7F;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign busy = (state_q != IDLE);

endmodule
